fc_layer_engine: RTL and testbench
==================================

# fc_layer_engine

Parametrised fully-connected classification layer and successor to the fixed 784×10 network top. It buffers one input vector, then computes N_OUT dot products on LANES parallel MAC lanes, time-multiplexed over N_OUT/LANES passes. Weights come from an external synchronous memory port. At the end it reports the argmax class with a start/done handshake. It sits between the pixel source and the result register / UART reporting logic.

## Interface
- DIN_W, 24: signed input sample width
- W_W, 24: signed weight width
- ACC_W, 32: signed accumulator / score width
- N_IN, 784: inputs per vector
- N_OUT, 10: neurons (classes); N_OUT % LANES == 0 is required (elaboration error otherwise)
- LANES, 10: parallel MAC lanes; PASSES = N_OUT/LANES
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse that begins a job; honoured only in IDLE
- in_valid  in  1  input sample valid
- in_ready  out  1  high only in LOAD
- in_data  in  DIN_W  input sample, two's complement
- w_rd_en  out  1  weight read strobe
- w_addr  out  $clog2(PASSES*N_IN_EFF)  word address; N_IN_EFF = N_IN (+1 with bias)
- w_data  in  LANES*W_W  weight word, lane l at bits [l*W_W +: W_W]; valid exactly 1 cycle after w_rd_en
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse when results are valid
- class_idx  out  $clog2(N_OUT)  argmax neuron index
- class_score  out  ACC_W  score of class_idx
- dft_cnt  out  $clog2(N_IN+1)  DFT: current element counter
- dft_acc0  out  ACC_W  DFT: lane-0 accumulator

## Operation
- States:
  - IDLE: start → LOAD.
  - LOAD: accepts in_data on in_valid&&in_ready into the internal N_IN×DIN_W buffer at index cnt. After the N_IN-th accept → MAC (pass 0).
  - MAC: issues reads k = 0..N_IN_EFF-1 with w_addr = p*N_IN_EFF + k and reads the buffer at k in the same cycle. The next cycle it adds product(buf[k], w_lane) into acc[l].
  - CMP: one cycle. Compares acc[0..LANES-1] against the running max.
  - After CMP: if p < PASSES-1, then p++ and → MAC; else → DONE.
  - DONE: asserts done for 1 cycle, then → IDLE.
- Accumulators are cleared at the start of every pass.
- Product is full DIN_W+W_W signed, sign-extended, then added.
- Accumulator saturates to [−2^(ACC_W−1), 2^(ACC_W−1)−1]; it never wraps.
- Argmax uses strict greater-than: ties keep the lowest neuron index (p*LANES+l). The running max is initialised to the most-negative value and index 0 at the start of the job.
- class_idx and class_score update only in DONE and hold until the next DONE or reset.
- start in any state other than IDLE is ignored. in_valid outside LOAD is ignored.
- The weight port has no backpressure. w_rd_en is high exactly on MAC issue cycles.

## Timing
- Reset: state IDLE. in_ready, busy, done, w_rd_en = 0. w_addr, class_idx, class_score, dft_cnt, dft_acc0 = 0. Accumulators and the running max are cleared. The buffer contents are don't-care.
- Reset mid-job aborts the job immediately. No done is produced; outputs return to their reset values.
- busy rises the cycle after start is sampled.
- LOAD takes N_IN accepted beats; gaps in in_valid stretch it.
- Each pass takes N_IN_EFF issue cycles + 1 drain cycle + 1 CMP cycle.
- Latency from the last accepted input to done = PASSES*(N_IN_EFF+2) + 1 cycles.
- A new start is accepted in the cycle after done.

## Configuration
- FC_BIAS_EN defined: N_IN_EFF = N_IN+1. Read k = N_IN of each pass returns per-lane biases (W_W, sign-extended to ACC_W), which are added with saturation and without a multiply.
- FC_BIAS_EN undefined: N_IN_EFF = N_IN and there is no bias read.

## Test plan
- N_IN=4, N_OUT=4, LANES=2, inputs {1,2,3,4}, neuron n weights all n+1 → scores {10,20,30,40}. Required: class_idx=3, class_score=40, done 13 cycles after the last input (no bias), w_addr sequence 0..7.
- Equal scores {5,9,9,2} → class_idx=1 (tie resolves to the lowest index).
- Inputs 2^23−1 with weights 2^23−1, ACC_W=32 → accumulator clamps at 2^31−1 with no sign flip. With all weights at −2^23, it clamps at −2^31.
- in_valid toggling every other cycle during LOAD: exactly 4 beats are accepted. A start pulse mid-MAC is ignored, and only one done is produced.
- reset asserted during pass 1: next cycle busy=0, class_idx=0, and no done. A subsequent full job gives the correct result.
- FC_BIAS_EN with biases {−15,0,0,0} on the first test → class_idx=3, score 40, pass length 7 cycles.

Source files
------------

// File: rtl/fc_layer_engine.sv
// Fully-connected layer: buffers one input vector, runs LANES parallel saturating MACs per pass, reports argmax.
// Optional macro FC_BIAS_EN: an extra weight word per pass carries per-lane biases.
module fc_layer_engine #(
  parameter int DIN_W = 24,
  parameter int W_W   = 24,
  parameter int ACC_W = 32,
  parameter int N_IN  = 784,
  parameter int N_OUT = 10,
  parameter int LANES = 10,
`ifdef FC_BIAS_EN
  localparam int N_IN_EFF = N_IN + 1,
`else
  localparam int N_IN_EFF = N_IN,
`endif
  localparam int PASSES = N_OUT / LANES,
  localparam int WA_W   = (PASSES * N_IN_EFF > 1) ? $clog2(PASSES * N_IN_EFF) : 1,
  localparam int IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int CNT_W  = $clog2(N_IN + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DIN_W-1:0]       in_data,
  output logic                   w_rd_en,
  output logic [WA_W-1:0]        w_addr,
  input  logic [LANES*W_W-1:0]   w_data,
  output logic                   busy,
  output logic                   done,
  output logic [IDX_W-1:0]       class_idx,
  output logic [ACC_W-1:0]       class_score,
  output logic [CNT_W-1:0]       dft_cnt,
  output logic [ACC_W-1:0]       dft_acc0
);

  localparam int PROD_W = DIN_W + W_W;
  localparam int EXT_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;
  localparam int AW     = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;

  localparam logic [CNT_W-1:0] LAST_LOAD  = CNT_W'(N_IN - 1);
  localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(N_IN_EFF - 1);
  localparam logic [PW-1:0]    LAST_PASS  = PW'(PASSES - 1);
  localparam logic [WA_W-1:0]  PASS_STRIDE = WA_W'(N_IN_EFF);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  generate
    if (N_OUT % LANES != 0) begin : g_bad_lanes
      $error("fc_layer_engine: N_OUT must be a multiple of LANES");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, CMP, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg;
  logic [PW-1:0]           pass_reg;
  logic [WA_W-1:0]         base_reg;
  logic [DIN_W-1:0]        sample_mem [N_IN];
  logic signed [DIN_W-1:0] rd_data_reg;
  logic                    add_en_reg, bias_en_reg;
  logic                    bias_issue, last_pass, acc_clr, accept;
  logic signed [ACC_W-1:0] acc_q [LANES];
  logic signed [ACC_W-1:0] max_score_reg, cmp_score, class_score_reg;
  logic [IDX_W-1:0]        max_idx_reg, cmp_idx, class_idx_reg;
  logic signed [PROD_W-1:0] din_ext;

  assign accept    = (state_reg == LOAD) && in_valid;
  assign last_pass = (pass_reg == LAST_PASS);
  assign acc_clr   = (state_reg == IDLE) || (state_reg == LOAD) ||
                     (state_reg == CMP)  || (state_reg == DONE);

`ifdef FC_BIAS_EN
  assign bias_issue = w_rd_en && (cnt_reg == CNT_W'(N_IN));
`else
  assign bias_issue = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    w_rd_en    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && cnt_reg == LAST_LOAD) state_next = MAC;
      end
      MAC: begin
        w_rd_en = 1'b1;
        if (cnt_reg == LAST_ISSUE) state_next = DRAIN;
      end
      DRAIN: state_next = CMP;
      CMP:   state_next = last_pass ? DONE : MAC;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // cnt_reg doubles as the load index and the per-pass issue index k
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg  <= '0;
      pass_reg <= '0;
      base_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg  <= '0;
          pass_reg <= '0;
          base_reg <= '0;
        end
        LOAD: if (in_valid) cnt_reg <= (cnt_reg == LAST_LOAD) ? '0 : cnt_reg + 1'b1;
        MAC:  cnt_reg <= (cnt_reg == LAST_ISSUE) ? '0 : cnt_reg + 1'b1;
        CMP: begin
          if (!last_pass) begin
            pass_reg <= pass_reg + 1'b1;
            base_reg <= base_reg + PASS_STRIDE;
          end
        end
        default: ;
      endcase
    end
  end

  // Input buffer with registered read, aligned with the synchronous weight port
  always_ff @(posedge clk) begin
    if (accept) sample_mem[cnt_reg[AW-1:0]] <= in_data;
    rd_data_reg <= sample_mem[cnt_reg[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      add_en_reg  <= 1'b0;
      bias_en_reg <= 1'b0;
    end else begin
      add_en_reg  <= w_rd_en;
      bias_en_reg <= bias_issue;
    end
  end

  assign din_ext = {{W_W{rd_data_reg[DIN_W-1]}}, rd_data_reg};

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [W_W-1:0]    w_lane;
      logic signed [PROD_W-1:0] w_ext, prod;
      logic signed [EXT_W-1:0]  addend, sum;
      logic signed [ACC_W-1:0]  acc_reg, acc_next;

      assign w_lane = w_data[gi*W_W +: W_W];
      assign w_ext  = {{DIN_W{w_lane[W_W-1]}}, w_lane};
      assign prod   = din_ext * w_ext;
      // Bias words bypass the multiplier and are added directly
      assign addend = bias_en_reg ? {{(EXT_W-W_W){w_lane[W_W-1]}}, w_lane}
                                  : {{(EXT_W-PROD_W){prod[PROD_W-1]}}, prod};
      assign sum    = {{(EXT_W-ACC_W){acc_reg[ACC_W-1]}}, acc_reg} + addend;

      always_comb begin
        acc_next = sum[ACC_W-1:0];
        if (sum > SAT_MAX)      acc_next = ACC_MAX;
        else if (sum < SAT_MIN) acc_next = ACC_MIN;
      end

      always_ff @(posedge clk) begin
        if (reset || acc_clr) acc_reg <= '0;
        else if (add_en_reg)  acc_reg <= acc_next;
      end

      assign acc_q[gi] = acc_reg;
    end
  endgenerate

  // Lowest lane wins ties because only a strictly larger score replaces the max
  always_comb begin
    cmp_score = max_score_reg;
    cmp_idx   = max_idx_reg;
    for (int l = 0; l < LANES; l++) begin
      if (acc_q[l] > cmp_score) begin
        cmp_score = acc_q[l];
        cmp_idx   = IDX_W'(int'(pass_reg) * LANES + l);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      max_score_reg   <= ACC_MIN;
      max_idx_reg     <= '0;
      class_score_reg <= '0;
      class_idx_reg   <= '0;
    end else if (state_reg == IDLE && start) begin
      max_score_reg <= ACC_MIN;
      max_idx_reg   <= '0;
    end else if (state_reg == CMP) begin
      max_score_reg <= cmp_score;
      max_idx_reg   <= cmp_idx;
      if (last_pass) begin
        class_score_reg <= cmp_score;
        class_idx_reg   <= cmp_idx;
      end
    end
  end

  assign w_addr      = w_rd_en ? base_reg + WA_W'(cnt_reg) : '0;
  assign class_idx   = class_idx_reg;
  assign class_score = class_score_reg;
  assign dft_cnt     = cnt_reg;
  assign dft_acc0    = acc_q[0];

endmodule

// File: tb/tb_fc_layer_engine.sv
// Bench for fc_layer_engine: directed jobs checked against a plain-arithmetic dot-product/argmax model.
// Honours FC_BIAS_EN so the same bench covers the bias build.
module tb_fc_layer_engine;
  localparam int DIN_W = 24, W_W = 24, ACC_W = 32;
  localparam int N_IN = 4, N_OUT = 4, LANES = 2;
  localparam int PASSES = N_OUT / LANES;
`ifdef FC_BIAS_EN
  localparam int NE = N_IN + 1;
  localparam int LAT_LIT = 15;
`else
  localparam int NE = N_IN;
  localparam int LAT_LIT = 13;
`endif
  localparam int WA_W = $clog2(PASSES * NE);
  localparam int IDX_W = $clog2(N_OUT);
  localparam int CNT_W = $clog2(N_IN + 1);
  localparam int LATENCY = PASSES * (NE + 2) + 1;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk, reset, start, in_valid, in_ready, w_rd_en, busy, done;
  logic [DIN_W-1:0] in_data;
  logic [WA_W-1:0] w_addr;
  logic [LANES*W_W-1:0] w_data;
  logic [IDX_W-1:0] class_idx;
  logic [ACC_W-1:0] class_score, dft_acc0;
  logic [CNT_W-1:0] dft_cnt;

  fc_layer_engine #(.DIN_W(DIN_W), .W_W(W_W), .ACC_W(ACC_W), .N_IN(N_IN),
                    .N_OUT(N_OUT), .LANES(LANES)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .w_rd_en(w_rd_en), .w_addr(w_addr),
    .w_data(w_data), .busy(busy), .done(done), .class_idx(class_idx),
    .class_score(class_score), .dft_cnt(dft_cnt), .dft_acc0(dft_acc0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous weight memory: data one cycle after the read strobe
  logic [LANES*W_W-1:0] wmem [PASSES*NE];
  always @(posedge clk) if (w_rd_en) w_data <= wmem[w_addr];

  int n_checks = 0, n_fail = 0;
  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  longint in_vec [N_IN];
  longint wt [N_OUT][N_IN];
  longint bias_v [N_OUT];
  longint exp_score;
  int exp_idx;
  bit expect_done = 0;

  function automatic longint sat(input longint x);
    if (x > SMAX) return SMAX;
    if (x < SMIN) return SMIN;
    return x;
  endfunction

  // Reference: per-neuron saturating dot product, then strict-greater argmax from most-negative
  task automatic build_model();
    longint s;
    exp_score = SMIN;
    exp_idx = 0;
    for (int n = 0; n < N_OUT; n++) begin
      s = 0;
      for (int k = 0; k < N_IN; k++) s = sat(s + in_vec[k] * wt[n][k]);
`ifdef FC_BIAS_EN
      s = sat(s + bias_v[n]);
`endif
      if (s > exp_score) begin
        exp_score = s;
        exp_idx = n;
      end
    end
    for (int p = 0; p < PASSES; p++)
      for (int l = 0; l < LANES; l++) begin
        for (int k = 0; k < N_IN; k++) wmem[p*NE+k][l*W_W +: W_W] = W_W'(wt[p*LANES+l][k]);
`ifdef FC_BIAS_EN
        wmem[p*NE+N_IN][l*W_W +: W_W] = W_W'(bias_v[p*LANES+l]);
`endif
      end
  endtask

  // Compare process: every cycle, sampled on the falling edge
  int cyc = 0, last_acc = 0, last_lat = 0, n_acc = 0, n_rd = 0, n_done = 0, exp_addr = 0;
  bit start_seen = 0;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      exp_addr = 0;
      start_seen = 0;
    end else begin
      if (start_seen) check("busy_after_start", busy, 1);
      start_seen = start && !busy;
      if (start_seen) exp_addr = 0;
      if (in_valid && in_ready) begin
        last_acc = cyc;
        n_acc++;
      end
      if (w_rd_en) begin
        check("w_addr", w_addr, exp_addr);
        exp_addr++;
        n_rd++;
      end
      if (!expect_done) check("done_when_idle", done, 0);
      else if (done) begin
        n_done++;
        last_lat = cyc - last_acc;
        check("done_latency", last_lat, LATENCY);
        check("class_idx", class_idx, exp_idx);
        check("class_score", longint'($signed(class_score)), exp_score);
        $display("job done: class_idx=%0d class_score=%0d latency=%0d",
                 class_idx, $signed(class_score), last_lat);
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic load_job(input bit gappy);
    int i = 0, guard = 0;
    bit tog = 0, acc_now;
    build_model();
    expect_done = 1'b1;
    pulse_start();
    while (i < N_IN && guard < 100) begin
      if (gappy && tog) begin
        in_valid = 1'b0;
        in_data = DIN_W'(999);
      end else begin
        in_valid = 1'b1;
        in_data = DIN_W'(in_vec[i]);
      end
      @(negedge clk);
      acc_now = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc_now) i++;
      tog = !tog;
      guard++;
    end
    if (guard >= 100) check("load_timeout", i, N_IN);
    // In the gappy case keep offering junk; it must be ignored outside LOAD
    if (gappy) begin
      in_valid = 1'b1;
      in_data = DIN_W'(12345);
    end else in_valid = 1'b0;
  endtask

  task automatic run_job(input bit gappy, input bit start_mid);
    int acc0, rd0, done0, guard = 0;
    acc0 = n_acc; rd0 = n_rd; done0 = n_done;
    load_job(gappy);
    if (start_mid) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    while (n_done == done0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    repeat (6) @(posedge clk);
    #1 in_valid = 1'b0;
    expect_done = 1'b0;
    check("done_count", n_done - done0, 1);
    check("beats_accepted", n_acc - acc0, N_IN);
    check("weight_reads", n_rd - rd0, PASSES * NE);
    check("busy_after_job", busy, 0);
  endtask

  task automatic set_basic();
    for (int k = 0; k < N_IN; k++) in_vec[k] = k + 1;
    for (int n = 0; n < N_OUT; n++) begin
      bias_v[n] = 0;
      for (int k = 0; k < N_IN; k++) wt[n][k] = n + 1;
    end
`ifdef FC_BIAS_EN
    bias_v[0] = -15;
`endif
  endtask

  task automatic set_uniform(input longint x, input longint w);
    for (int k = 0; k < N_IN; k++) in_vec[k] = x;
    for (int n = 0; n < N_OUT; n++) begin
      bias_v[n] = 0;
      for (int k = 0; k < N_IN; k++) wt[n][k] = w;
    end
  endtask

  initial begin
    longint tie_w [N_OUT];
    int guard, done0;
    tie_w = '{5, 9, 9, 2};
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_w_rd_en", w_rd_en, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_class_idx", class_idx, 0);
    check("rst_class_score", class_score, 0);
    check("rst_dft_cnt", dft_cnt, 0);
    check("rst_dft_acc0", dft_acc0, 0);

    // Scores {10,20,30,40}
    set_basic();
    run_job(0, 0);
    check("basic_idx_lit", class_idx, 3);
    check("basic_score_lit", longint'($signed(class_score)), 40);
    check("basic_latency_lit", last_lat, LAT_LIT);

    // Scores {5,9,9,2}: tie keeps the lower index
    for (int k = 0; k < N_IN; k++) in_vec[k] = (k == 0) ? 1 : 0;
    for (int n = 0; n < N_OUT; n++) begin
      bias_v[n] = 0;
      for (int k = 0; k < N_IN; k++) wt[n][k] = tie_w[n];
    end
    run_job(0, 0);
    check("tie_idx_lit", class_idx, 1);
    check("tie_score_lit", longint'($signed(class_score)), 9);

    set_uniform(64'sd8388607, 64'sd8388607);
    run_job(0, 0);
    check("satpos_score_lit", longint'($signed(class_score)), 2147483647);
    check("satpos_idx_lit", class_idx, 0);

    set_uniform(64'sd8388607, -64'sd8388608);
    run_job(0, 0);
    check("satneg_score_lit", longint'($signed(class_score)), -64'sd2147483648);
    check("satneg_idx_lit", class_idx, 0);

    // Gappy in_valid, junk after LOAD, stray start mid-MAC
    set_basic();
    run_job(1, 1);
    check("gappy_idx_lit", class_idx, 3);

    // Reset during pass 1
    done0 = n_done;
    load_job(0);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(w_rd_en && w_addr >= WA_W'(NE)) && guard < 100);
    check("reached_pass1", int'(w_addr >= WA_W'(NE)), 1);
    expect_done = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_class_idx", class_idx, 0);
    check("abort_class_score", class_score, 0);
    check("abort_w_rd_en", w_rd_en, 0);
    check("abort_dft_acc0", dft_acc0, 0);
    repeat (30) @(posedge clk);
    check("abort_no_done", n_done - done0, 0);

    set_basic();
    run_job(0, 0);
    check("after_abort_idx_lit", class_idx, 3);
    check("after_abort_score_lit", longint'($signed(class_score)), 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
